// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_WIDTH  = 8;
  localparam int unsigned FETCH_DATA_WIDTH  = 8;
  localparam int unsigned FETCH_QUEUE_DEPTH = 2;

  localparam logic [FETCH_ADDR_WIDTH-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] instruction;
    logic [FETCH_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_queue.sv
// Two-entry FIFO of fetched {instruction, pc} pairs with flush; push and pop may coincide.
module fetch_skid_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [FETCH_QUEUE_DEPTH];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic [1:0]   w_count_d;

  always_comb begin
    w_count_d = r_count;
    if (i_flush) begin
      w_count_d = '0;
    end else if (i_push && !i_pop) begin
      w_count_d = r_count + 2'd1;
    end else if (i_pop && !i_push) begin
      w_count_d = r_count - 2'd1;
    end
  end

  // Depth is two, so single-bit pointers simply toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_QUEUE_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_flush) begin
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        if (i_push) begin
          r_mem[r_wr_ptr] <= i_push_entry;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (i_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
      end
      r_count <= w_count_d;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  push_not_full_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_flush && (r_count == 2'(FETCH_QUEUE_DEPTH))));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-based issue to a 1-cycle synchronous memory, and a 2-entry
// output queue feeding the decoder over valid/ready, with jump redirect and flush.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = FETCH_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_fetch_en,
  input  logic                  i_jump_valid,
  input  logic [ADDR_WIDTH-1:0] i_jump_target,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_instr_valid,
  input  logic                  i_instr_ready,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0] o_instr_pc
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_tag;
  logic                  r_inflight;

  logic [1:0]   w_count;
  logic [1:0]   w_occupancy;
  logic         w_pop;
  logic         w_push;
  logic         w_squash;
  logic         w_issue;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;

  assign o_instr_valid = (w_count != 2'd0);
  assign w_pop         = o_instr_valid & i_instr_ready;
  assign w_occupancy   = w_count + {1'b0, r_inflight};

  // Reset gates the strobe combinationally so the memory sees no read while held in reset.
  assign w_issue = rst_n & i_fetch_en & !i_jump_valid
                 & ((w_occupancy - {1'b0, w_pop}) < 2'd2);

  // Data returning in a jump cycle belongs to the old stream and is dropped.
  assign w_squash     = r_inflight & i_jump_valid;
  assign w_push       = r_inflight & !w_squash;
  assign w_push_entry = '{instruction: i_mem_rdata, pc: r_tag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= ADDR_WIDTH'(RESET_PC);
      r_tag      <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (i_jump_valid) begin
        r_pc <= i_jump_target;
      end else if (w_issue) begin
        r_pc <= r_pc + ADDR_WIDTH'(1);
      end
      if (w_issue) begin
        r_tag <= r_pc;
      end
      r_inflight <= w_issue;
    end
  end

  fetch_skid_queue u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (i_jump_valid),
    .o_count      (w_count),
    .o_head       (w_head)
  );

  assign o_mem_rd_en   = w_issue;
  assign o_mem_addr    = r_pc;
  assign o_instruction = o_instr_valid ? w_head.instruction : '0;
  assign o_instr_pc    = o_instr_valid ? w_head.pc : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_en;
  logic       jump_valid;
  logic [7:0] jump_target;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instruction;
  logic [7:0] instr_pc;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [7:0] q_instr [$];
  logic [7:0] q_pc    [$];
  logic [7:0] m_pc;
  logic       m_infl;
  logic [7:0] m_infl_addr;

  logic [7:0] t1_bytes [4];

  always #5 clk = ~clk;

  // Program memory: mem[a] = a ^ A5, one-cycle latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_addr ^ 8'hA5;
  end

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_fetch_en    (fetch_en),
    .i_jump_valid  (jump_valid),
    .i_jump_target (jump_target),
    .o_mem_rd_en   (mem_rd_en),
    .o_mem_addr    (mem_addr),
    .i_mem_rdata   (mem_rdata),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .o_instruction (instruction),
    .o_instr_pc    (instr_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_instr.delete();
    q_pc.delete();
    m_pc        = 8'h00;
    m_infl      = 1'b0;
    m_infl_addr = 8'h00;
  endtask

  // One cycle: drive just after the rising edge, compare at the falling edge, advance model.
  task automatic step(input logic fe, input logic jv, input logic [7:0] jt, input logic rdy);
    logic pop;
    logic exp_rd;
    int   occ;
    @(posedge clk);
    #1;
    fetch_en    = fe;
    jump_valid  = jv;
    jump_target = jt;
    instr_ready = rdy;
    @(negedge clk);
    pop    = (q_instr.size() > 0) && rdy;
    occ    = q_instr.size() + int'(m_infl) - int'(pop);
    exp_rd = fe && !jv && (occ < 2);
    check("rd_en", mem_rd_en, exp_rd);
    check("mem_addr", mem_addr, m_pc);
    check("valid", instr_valid, q_instr.size() > 0);
    check("instr", instruction, (q_instr.size() > 0) ? q_instr[0] : 8'h00);
    check("instr_pc", instr_pc, (q_pc.size() > 0) ? q_pc[0] : 8'h00);
    if (pop) begin
      void'(q_instr.pop_front());
      void'(q_pc.pop_front());
    end
    if (jv) begin
      q_instr.delete();
      q_pc.delete();
      m_pc   = jt;
      m_infl = 1'b0;
    end else begin
      if (m_infl) begin
        q_instr.push_back(m_infl_addr ^ 8'hA5);
        q_pc.push_back(m_infl_addr);
      end
      m_infl = exp_rd;
      if (exp_rd) begin
        m_infl_addr = m_pc;
        m_pc        = m_pc + 8'd1;
      end
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear before any edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instruction, 8'h00);
    check("rst_pc", instr_pc, 8'h00);
    model_reset();
    fetch_en    = 1'b0;
    jump_valid  = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int obs;
    t1_bytes[0] = 8'hA5;
    t1_bytes[1] = 8'hA4;
    t1_bytes[2] = 8'hA7;
    t1_bytes[3] = 8'hA6;
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    jump_valid  = 1'b0;
    jump_target = 8'h00;
    instr_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rd_en", mem_rd_en, 1'b0);
    check("reset_valid", instr_valid, 1'b0);
    check("reset_addr", mem_addr, 8'h00);
    rst_n = 1'b1;

    // Streaming, jump to 40 at cycle 6, jump to FE at 12, fetch_en gap at 20..22
    for (int c = 0; c < 26; c++) begin
      step(!(c >= 20 && c <= 22), (c == 6) || (c == 12), (c == 6) ? 8'h40 : 8'hFE, 1'b1);
      if (c <= 5) check("t1_rd_en", mem_rd_en, 1'b1);
      case (c)
        2, 3, 4, 5: begin
          check("t1_instr", instruction, t1_bytes[c-2]);
          check("t1_pc", instr_pc, c - 2);
        end
        7, 8: check("jmp_gap_valid", instr_valid, 1'b0);
        9: begin
          check("jmp_instr", instruction, 8'hE5);
          check("jmp_pc", instr_pc, 8'h40);
        end
        15: begin
          check("wrap_pc0", instr_pc, 8'hFE);
          check("wrap_b0", instruction, 8'h5B);
        end
        16: begin
          check("wrap_pc1", instr_pc, 8'hFF);
          check("wrap_b1", instruction, 8'h5A);
        end
        17: begin
          check("wrap_pc2", instr_pc, 8'h00);
          check("wrap_b2", instruction, 8'hA5);
        end
        21: begin
          check("fe_last_pc", instr_pc, 8'h04);
          check("fe_last_b", instruction, 8'hA1);
        end
        22: begin
          check("fe_drained", instr_valid, 1'b0);
          check("fe_pc_hold", mem_addr, 8'h05);
        end
        25: begin
          check("fe_resume_pc", instr_pc, 8'h05);
          check("fe_resume_b", instruction, 8'hA0);
        end
        default: ;
      endcase
    end

    // Reset mid-stream with a read in flight, then restart from address 0
    mid_reset();
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1);
      if (c == 2) begin
        check("rst_restart_b", instruction, 8'hA5);
        check("rst_restart_pc", instr_pc, 8'h00);
      end
    end

    // Backpressure from reset
    mid_reset();
    obs = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      if (mem_rd_en) obs++;
    end
    check("bp_issues", obs, 2);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("bp_pop0", instruction, 8'hA5);
    check("bp_reissue", mem_rd_en, 1'b1);
    check("bp_reissue_addr", mem_addr, 8'h02);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("bp_pop1", instruction, 8'hA4);

    // Randomized traffic, including back-to-back jumps and occasional async resets
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 8'($urandom),
           $urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of `instruction_decoder`: maintains the program counter and issues reads to a synchronous program memory. It buffers returned bytes in a 2-entry queue and presents them to the decoder over a valid/ready handshake. It supports jump redirection with flush, and a fetch-enable gate. Sustains one instruction per cycle when the decoder is always ready.

## Interface
- `ADDR_WIDTH`, 8, program-counter / memory address width
- `DATA_WIDTH`, 8, instruction width; matches the decoder's `instruction` input

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `fetch_en`  in  1  when 1, new memory reads may be issued
- `jump_valid`  in  1  redirect request; highest priority
- `jump_target`  in  ADDR_WIDTH  new PC when `jump_valid`=1
- `mem_rd_en`  out  1  read strobe to program memory
- `mem_addr`  out  ADDR_WIDTH  read address; equals PC register
- `mem_rdata`  in  DATA_WIDTH  read data, valid exactly 1 cycle after `mem_rd_en`
- `instr_valid`  out  1  queue head holds an instruction
- `instr_ready`  in  1  decoder accepts head this cycle
- `instruction`  out  DATA_WIDTH  queue head byte, drives the decoder
- `instr_pc`  out  ADDR_WIDTH  address the head byte was fetched from

## Operation
- Reset (async assert): PC=0, queue empty, in-flight=0, squash=0. Outputs: `mem_rd_en`=0, `mem_addr`=0, `instr_valid`=0, `instruction`=0, `instr_pc`=0.
- Credit rule: `occupancy` = queue count + in-flight read (0/1), max 2. `pop` = `instr_valid & instr_ready`.
- Issue: `mem_rd_en` = `fetch_en & !jump_valid & (occupancy - pop < 2)`. It is combinational from registers and inputs. On issue, PC <= PC+1, wrapping from 2^ADDR_WIDTH-1 to 0. The issuing address is tagged and carried with the in-flight read.
- Return: the cycle after an issue, `{mem_rdata, tag}` is written to the queue tail unless squashed.
- Queue: 2 entries. Push and pop may occur in the same cycle. Order is preserved. Push to a full queue cannot occur under the credit rule; assert this in simulation.
- Jump (`jump_valid`=1):
  - PC <= `jump_target`.
  - The queue is flushed at the clock edge.
  - Any read in flight is marked squashed, and its data is dropped next cycle.
  - No issue occurs in the jump cycle.
- Jump with a simultaneous `pop`: the popped instruction counts as consumed; flush affects only remaining entries.
- `fetch_en`=0: no new issue. An in-flight read still completes into the queue, and the queue still drains to the decoder. PC holds.
- Back-to-back jumps: each one overrides the PC. The last one wins.
- `instr_ready` is ignored while `instr_valid`=0.
- `instruction`/`instr_pc` are stable while `instr_valid`=1 and `instr_ready`=0.

## Timing
- Issue at cycle N: byte enters the queue at edge N+1→N+2, and `instr_valid`=1 in cycle N+2. Fetch-to-decoder latency is 2 cycles.
- First issue after reset release: the first cycle with `rst_n`=1 and `fetch_en`=1, with `mem_addr`=0.
- Steady state with `instr_ready`=1: one issue and one pop per cycle. There are no bubbles after the initial 2-cycle fill.
- Jump in cycle J: first issue at `jump_target` in cycle J+1. First target instruction is valid in J+3. `instr_valid`=0 in J+1 and J+2.
- Backpressure: with `instr_ready`=0, at most 2 instructions are outstanding. `mem_rd_en` stays low until a pop frees credit. Issue resumes in the same cycle as that pop.
- Reset mid-operation: all state clears immediately, regardless of the clock. In-flight data returning after reset release is ignored.

## Structure
- Package `fetch_pkg`:
  - `FETCH_QUEUE_DEPTH`=2
  - `RESET_PC`=0
  - entry typedef `fetch_entry_t` = {instruction, pc}
- Sub-module `fetch_skid_queue`:
  - 2-entry FIFO of `fetch_entry_t` with push, pop, flush, count, head outputs.
  - Async active-low reset on `clk`/`rst_n`.
- Top-level holds the PC, in-flight/squash flags, and the credit logic.

## Test plan
Memory model: mem[a] = a XOR 8'hA5, 1-cycle read latency.
- Reset, `fetch_en`=1, `instr_ready`=1: cycles 2..5 show `instruction` = A5, A4, A7, A6 and `instr_pc` = 0..3. `mem_rd_en` stays high continuously.
- `instr_ready`=0 from reset: exactly 2 issues (addr 0, 1), then `mem_rd_en`=0. After 10 cycles, raise ready: A5 then A4 pop, and the issue at addr 2 occurs in the first pop cycle.
- Jump to 8'h40 in cycle 6 during streaming: the in-flight byte and queue contents are dropped. `instr_valid`=0 in cycles 7 and 8. Cycle 9 shows `instruction`=E5, `instr_pc`=40.
- PC wrap: jump to 8'hFE. The sequence is pc FE, FF, 00 with bytes 5B, 5A, A5.
- `fetch_en` drops while a read is in flight: the in-flight byte still appears, then `instr_valid` falls and the PC holds. Re-enabling resumes at the next address with no gap or duplicate.
- Assert `rst_n`=0 mid-stream with an in-flight read: all outputs are 0 immediately. After release, the fetch restarts at addr 0 with byte A5.
